// File: rtl/led_trace_player.sv
// led_trace_player: queues firmware LED debug codes in a FIFO and shows each on led_out for HOLD_CYCLES clocks.
// Optional build macro LED_TRACE_DEDUP_EN discards a write equal to the last accepted write.
module led_trace_player #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_ovf,
  output logic [7:0]               led_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              TW         = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0]   HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]     FULL_LEVEL = (PW+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      led_out_q, led_out_d;
  logic            overflow_q, overflow_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            timer_done;
  logic            pop;
  logic            push;
  logic            drop;
  logic            wr_dup;
  logic            busy_s;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LEVEL);
  assign timer_done = (timer_q == '0);

  // A pop frees a slot in the same cycle, so a write into a full FIFO is kept when a pop coincides.
  assign push = wr_en && !wr_dup && (!fifo_full || pop);
  assign drop = wr_en && !wr_dup && fifo_full && !pop;

`ifdef LED_TRACE_DEDUP_EN
  logic [7:0] last_q, last_d;
  logic       last_valid_q, last_valid_d;

  assign wr_dup = last_valid_q && (wr_data == last_q);

  always_comb begin
    last_d       = last_q;
    last_valid_d = last_valid_q;
    if (push) begin
      last_d       = wr_data;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= 8'h00;
      last_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign wr_dup = 1'b0;
`endif

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SHOW;
      SHOW:    if (timer_done && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s = 1'b0;
    pop    = 1'b0;
    case (state_q)
      IDLE: pop = !fifo_empty;
      SHOW: begin
        busy_s = 1'b1;
        pop    = timer_done && !fifo_empty;
      end
      default: begin
        busy_s = 1'b0;
        pop    = 1'b0;
      end
    endcase
  end

  // FIFO pointers, occupancy, display register, hold timer and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    timer_d    = timer_q;
    led_out_d  = led_out_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      led_out_d = mem_q[rd_ptr_q];
      timer_d   = HOLD_LOAD;
    end else if ((state_q == SHOW) && !timer_done) begin
      timer_d = timer_q - 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear wins, so no dropped write goes unreported.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      timer_q    <= '0;
      led_out_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      led_out_q  <= led_out_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign led_out  = led_out_q;
  assign busy     = busy_s;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_led_trace_player.sv
// tb_led_trace_player: table-driven check of led_trace_player with DEPTH=4, HOLD_CYCLES=4,
// plus a hand-written asynchronous reset sequence.
module tb_led_trace_player;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic [7:0] led_out;
  logic       busy;
  logic [2:0] level;
  logic       overflow;

  led_trace_player #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .led_out  (led_out),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       clr;
    logic [7:0] led;
    logic       busy;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic we, input logic [7:0] d, input logic clr,
                     input logic [7:0] led, input logic b, input logic [2:0] l, input logic o);
    vec_t v;
    v = '{we, d, clr, led, b, l, o};
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic [7:0] led, input logic b,
                          input logic [2:0] l, input logic o);
    for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, led, b, l, o);
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic clr);
    wr_en   = we;
    wr_data = d;
    clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] led, input logic b,
                            input logic [2:0] l, input logic o);
    check({tag, " led_out"},  led_out,  led);
    check({tag, " busy"},     busy,     b);
    check({tag, " level"},    level,    l);
    check({tag, " overflow"}, overflow, o);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;

    // Each row: inputs sampled at the next edge, outputs expected just after that edge.
    // Single write: idle edges 1-4, write 0x10 at edge 5, shown edges 6-9, back to IDLE at edge 10.
    add_idle(4, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
    add_idle(4, 8'h10, 1'b1, 3'd0, 1'b0);
    add_idle(2, 8'h10, 1'b0, 3'd0, 1'b0);

    // Burst of three: each code held four cycles, level peaks at 2.
    add(1'b1, 8'h01, 1'b0, 8'h10, 1'b0, 3'd1, 1'b0);
    add(1'b1, 8'h03, 1'b0, 8'h01, 1'b1, 3'd1, 1'b0);
    add(1'b1, 8'h06, 1'b0, 8'h01, 1'b1, 3'd2, 1'b0);
    add_idle(2, 8'h01, 1'b1, 3'd2, 1'b0);
    add_idle(4, 8'h03, 1'b1, 3'd1, 1'b0);
    add_idle(4, 8'h06, 1'b1, 3'd0, 1'b0);
    add_idle(1, 8'h06, 1'b0, 3'd0, 1'b0);

    // Fill to full. The sixth write lands on the second pop and is accepted at full;
    // the seventh meets a full FIFO with no pop and is dropped. A drop alongside
    // clr_ovf keeps overflow set; clr_ovf alone clears it. Pointers wrap during drain.
    add(1'b1, 8'h10, 1'b0, 8'h06, 1'b0, 3'd1, 1'b0);
    add(1'b1, 8'h11, 1'b0, 8'h10, 1'b1, 3'd1, 1'b0);
    add(1'b1, 8'h12, 1'b0, 8'h10, 1'b1, 3'd2, 1'b0);
    add(1'b1, 8'h13, 1'b0, 8'h10, 1'b1, 3'd3, 1'b0);
    add(1'b1, 8'h14, 1'b0, 8'h10, 1'b1, 3'd4, 1'b0);
    add(1'b1, 8'h15, 1'b0, 8'h11, 1'b1, 3'd4, 1'b0);
    add(1'b1, 8'h16, 1'b0, 8'h11, 1'b1, 3'd4, 1'b1);
    add(1'b1, 8'h17, 1'b1, 8'h11, 1'b1, 3'd4, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 3'd4, 1'b0);
    add_idle(4, 8'h12, 1'b1, 3'd3, 1'b0);
    add_idle(4, 8'h13, 1'b1, 3'd2, 1'b0);
    add_idle(4, 8'h14, 1'b1, 3'd1, 1'b0);
    add_idle(4, 8'h15, 1'b1, 3'd0, 1'b0);
    add_idle(1, 8'h15, 1'b0, 3'd0, 1'b0);

    // Repeated code: discarded with dedup, otherwise shown twice (12 busy cycles in total).
`ifdef LED_TRACE_DEDUP_EN
    add(1'b1, 8'h1e, 1'b0, 8'h15, 1'b0, 3'd1, 1'b0);
    add(1'b1, 8'h1e, 1'b0, 8'h1e, 1'b1, 3'd0, 1'b0);
    add(1'b1, 8'h20, 1'b0, 8'h1e, 1'b1, 3'd1, 1'b0);
    add_idle(2, 8'h1e, 1'b1, 3'd1, 1'b0);
    add_idle(4, 8'h20, 1'b1, 3'd0, 1'b0);
    add_idle(1, 8'h20, 1'b0, 3'd0, 1'b0);
`else
    add(1'b1, 8'h1e, 1'b0, 8'h15, 1'b0, 3'd1, 1'b0);
    add(1'b1, 8'h1e, 1'b0, 8'h1e, 1'b1, 3'd1, 1'b0);
    add(1'b1, 8'h20, 1'b0, 8'h1e, 1'b1, 3'd2, 1'b0);
    add_idle(2, 8'h1e, 1'b1, 3'd2, 1'b0);
    add_idle(4, 8'h1e, 1'b1, 3'd1, 1'b0);
    add_idle(4, 8'h20, 1'b1, 3'd0, 1'b0);
    add_idle(1, 8'h20, 1'b0, 3'd0, 1'b0);
`endif

    // Reset values with the clock running.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].d, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].led, vecs[i].busy, vecs[i].lvl, vecs[i].ovf);
    end

    // Reset in the middle of SHOW with three codes queued.
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    check_outs("pre_rst", 8'h31, 1'b1, 3'd3, 1'b0);

    #2;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    rst     = 1'b1;
    #1;
    check_outs("async_rst", 8'h00, 1'b0, 3'd0, 1'b0);

    @(posedge clk);
    #1;
    check_outs("wr_in_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    rst   = 1'b0;
    wr_en = 1'b0;

    step(1'b0, 8'h00, 1'b0);
    check_outs("post_rst_idle", 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h2f, 1'b0);
    check_outs("post_rst_push", 8'h00, 1'b0, 3'd1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_outs("post_rst_show", 8'h2f, 1'b1, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
